// File: rtl/minv_shreg_w.sv
// minv_shreg_w: word-serial WIDTH-bit operand register for the modular-inverse
// datapath. Supports word load/unload, single-bit right shift, set-to-one,
// clear and strip-trailing-zeros, and exports zero/one/LSB flags.
//
// state  | meaning
// IDLE   | accepting commands; SHR1/SET1/CLR complete here in one edge
// LOAD   | shifting in WORDS words from din, stalls while din_valid=0
// UNLOAD | rotating q right by WORD for WORDS edges, presenting each word on dout
// STRIP  | shifting q right while it is non-zero and even, counting in zcnt
module minv_shreg_w #(
  parameter int WIDTH = 256,
  parameter int WORD  = 16,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             shift_in,
  input  logic [WORD-1:0]  din,
  input  logic             din_valid,
  output logic [WORD-1:0]  dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] q,
  output logic             lsb,
  output logic             is_zero,
  output logic             is_one,
  output logic [CW-1:0]    zcnt,
  output logic             strip_done
);

  localparam int WORDS = WIDTH / WORD;
  localparam int CNTW  = $clog2(WORDS) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] UNLOAD = 2'd2;
  localparam logic [1:0] STRIP  = 2'd3;

  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_UNLOAD = 3'd2;
  localparam logic [2:0] OP_SHR1   = 3'd3;
  localparam logic [2:0] OP_SET1   = 3'd4;
  localparam logic [2:0] OP_CLR    = 3'd5;
  localparam logic [2:0] OP_STRIP  = 3'd6;

  logic [1:0]      state;
  logic [CNTW-1:0] cnt;
  logic            last_word;

  assign last_word = (cnt == CNTW'(WORDS - 1));

  // Ready is withheld while reset is held so nothing is accepted on release.
  assign cmd_ready = (state == IDLE) && !rst;

  // Flags are derived straight from the register so they are valid in every state.
  assign lsb     = q[0];
  assign is_zero = (q == '0);
  assign is_one  = (q == WIDTH'(1));

  // Command sequencing and all register updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      q          <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      zcnt       <= '0;
      strip_done <= 1'b0;
    end else begin
      // Pulses default low; dout keeps the last unloaded word.
      strip_done <= 1'b0;
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                cnt   <= '0;
                state <= LOAD;
              end
              OP_UNLOAD: begin
                cnt   <= '0;
                state <= UNLOAD;
              end
              OP_SHR1:  q <= {shift_in, q[WIDTH-1:1]};
              OP_SET1:  q <= WIDTH'(1);
              OP_CLR:   q <= '0;
              OP_STRIP: begin
                zcnt  <= '0;
                state <= STRIP;
              end
              default: ;
            endcase
          end
        end
        LOAD: begin
          if (din_valid) begin
            q   <= {din, q[WIDTH-1:WORD]};
            cnt <= cnt + CNTW'(1);
            if (last_word) state <= IDLE;
          end
        end
        UNLOAD: begin
          dout       <= q[WORD-1:0];
          dout_valid <= 1'b1;
          q          <= {q[WORD-1:0], q[WIDTH-1:WORD]};
          cnt        <= cnt + CNTW'(1);
          if (last_word) state <= IDLE;
        end
        STRIP: begin
          // q == 0 is excluded so an all-zero operand exits at once with zcnt 0.
          if (!is_zero && !q[0]) begin
            q    <= q >> 1;
            zcnt <= zcnt + CW'(1);
          end else begin
            state      <= IDLE;
            strip_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minv_shreg_w.sv
// Testbench for minv_shreg_w: transaction-level reference model plus directed
// vectors with hand-computed expectations.
module tb_minv_shreg_w;

  localparam int W = 256;
  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_UNLOAD = 3'd2, OP_SHR1 = 3'd3,
                         OP_SET1 = 3'd4, OP_CLR = 3'd5, OP_STRIP = 3'd6;

  logic          clk, rst, cmd_valid, shift_in, din_valid;
  logic [2:0]    cmd_op;
  logic [15:0]   din;
  logic          cmd_ready, dout_valid, lsb, is_zero, is_one, strip_done;
  logic [15:0]   dout;
  logic [W-1:0]  q;
  logic [8:0]    zcnt;

  minv_shreg_w dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .shift_in(shift_in), .din(din), .din_valid(din_valid), .dout(dout),
    .dout_valid(dout_valid), .q(q), .lsb(lsb), .is_zero(is_zero), .is_one(is_one),
    .zcnt(zcnt), .strip_done(strip_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks each multi-cycle operation by its step index from the value captured
  // at acceptance, rather than by mimicking a per-edge register update.
  logic [W-1:0] m_q, m_orig;
  logic [15:0]  m_dout;
  logic         m_dv, m_sd;
  logic [8:0]   m_zcnt;
  int           m_mode;   // 0 idle, 1 load, 2 unload, 3 strip
  int           m_step, m_k;

  function automatic int tz(input logic [W-1:0] x);
    for (int i = 0; i < W; i++) if (x[i]) return i;
    return 0;
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    if (n % W == 0) return x;
    return (x >> n) | (x << (W - n));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = '0; m_orig = '0; m_dout = '0; m_dv = 0; m_sd = 0; m_zcnt = '0;
      m_mode = 0; m_step = 0; m_k = 0;
    end else begin
      m_dv = 0;
      m_sd = 0;
      case (m_mode)
        0: if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD:   begin m_mode = 1; m_step = 0; end
            OP_UNLOAD: begin m_mode = 2; m_step = 0; m_orig = m_q; end
            OP_SHR1:   m_q = (m_q >> 1) | (W'(shift_in) << (W - 1));
            OP_SET1:   m_q = W'(1);
            OP_CLR:    m_q = '0;
            OP_STRIP:  begin
              m_mode = 3; m_step = 0; m_orig = m_q; m_zcnt = '0;
              m_k = (m_q == '0) ? 0 : tz(m_q);
            end
            default: ;
          endcase
        end
        1: if (din_valid) begin
          m_q = (m_q >> 16) | (W'(din) << (W - 16));
          m_step++;
          if (m_step == W / 16) m_mode = 0;
        end
        2: begin
          m_step++;
          m_dout = 16'(m_orig >> ((m_step - 1) * 16));
          m_dv = 1;
          m_q = rotr(m_orig, m_step * 16);
          if (m_step == W / 16) m_mode = 0;
        end
        default: begin
          m_step++;
          if (m_step <= m_k) begin
            m_q = m_orig >> m_step;
            m_zcnt = 9'(m_step);
          end else begin
            m_mode = 0;
            m_sd = 1;
          end
        end
      endcase
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", q, m_q);
      chk("lsb", W'(lsb), W'(m_q[0]));
      chk("is_zero", W'(is_zero), W'(m_q == '0));
      chk("is_one", W'(is_one), W'(m_q == W'(1)));
      chk("cmd_ready", W'(cmd_ready), W'((m_mode == 0) && !rst));
      chk("dout", W'(dout), W'(m_dout));
      chk("dout_valid", W'(dout_valid), W'(m_dv));
      chk("zcnt", W'(zcnt), W'(m_zcnt));
      chk("strip_done", W'(strip_done), W'(m_sd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic sh);
    cmd_valid = 1'b1; cmd_op = op; shift_in = sh;
    step();
    cmd_valid = 1'b0; cmd_op = OP_NOP; shift_in = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v, input int gap_after);
    din_valid = 1'b1; din = 16'hBEEF;   // present on the acceptance edge; must be ignored
    issue(OP_LOAD, 1'b0);
    for (int i = 0; i < 16; i++) begin
      din = v[16*i +: 16]; din_valid = 1'b1;
      step();
      if (i == gap_after) begin
        din_valid = 1'b0; din = 16'hDEAD;
        repeat (3) step();
      end
    end
    din_valid = 1'b0; din = '0;
  endtask

  task automatic run_strip(output int n);
    issue(OP_STRIP, 1'b0);
    n = 0;
    while (n < 400) begin
      step();
      n++;
      if (strip_done) break;
    end
  endtask

  localparam logic [W-1:0] LOADVAL =
    256'h0010_000F_000E_000D_000C_000B_000A_0009_0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [W-1:0] LOADVAL2 =
    256'hA00F_A00E_A00D_A00C_A00B_A00A_A009_A008_A007_A006_A005_A004_A003_A002_A001_A000;

  logic [15:0]  got[$];
  logic [W-1:0] top1, top2;
  int n;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; shift_in = 1'b0;
    din = '0; din_valid = 1'b0;
    top1 = '0; top1[255] = 1'b1;
    top2 = '0; top2[254] = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_q", q, '0);
    chk("rst_dout", W'(dout), '0);
    chk("rst_dout_valid", W'(dout_valid), '0);
    chk("rst_zcnt", W'(zcnt), '0);
    chk("rst_strip_done", W'(strip_done), '0);
    chk("rst_is_zero", W'(is_zero), W'(1));
    step();
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", W'(cmd_ready), W'(1));
    chk_en = 1'b1;

    // LOAD with a 3-cycle din_valid gap after word 5
    do_load(LOADVAL, 4);
    chk("load_q", q, LOADVAL);
    chk("load_ready_after", W'(cmd_ready), W'(1));

    // UNLOAD: 16 contiguous words, least significant first, q restored
    issue(OP_UNLOAD, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (dout_valid) got.push_back(dout);
    end
    chk("unload_count", W'(got.size()), W'(16));
    for (int i = 0; i < got.size(); i++) chk("unload_word", W'(got[i]), W'(i + 1));
    chk("unload_q_restored", q, LOADVAL);
    chk("unload_dv_after", W'(dout_valid), '0);
    chk("unload_dout_hold", W'(dout), W'(16'h0010));

    // SET1 then SHR1 with fill 1, then fill 0
    issue(OP_SET1, 1'b0);
    chk("set1_is_one", W'(is_one), W'(1));
    issue(OP_SHR1, 1'b1);
    chk("shr1_top", q, top1);
    chk("shr1_lsb", W'(lsb), '0);
    issue(OP_SHR1, 1'b0);
    chk("shr1_second", q, top2);

    // STRIP on 40: three shifts, q = 5, done seen after E4
    do_load(W'(40), -1);
    run_strip(n);
    chk("strip40_q", q, W'(5));
    chk("strip40_zcnt", W'(zcnt), W'(3));
    chk("strip40_edges", W'(n), W'(4));
    chk("strip40_ready", W'(cmd_ready), W'(1));

    // STRIP on 0: immediate exit
    issue(OP_CLR, 1'b0);
    run_strip(n);
    chk("strip0_zcnt", W'(zcnt), '0);
    chk("strip0_edges", W'(n), W'(1));

    // STRIP on 2^255: 255 shifts down to 1
    issue(OP_SET1, 1'b0);
    issue(OP_SHR1, 1'b1);
    run_strip(n);
    chk("strip_top_zcnt", W'(zcnt), W'(255));
    chk("strip_top_q", q, W'(1));
    chk("strip_top_edges", W'(n), W'(256));

    // Reserved opcode leaves q alone
    issue(3'd7, 1'b1);
    chk("reserved_q", q, W'(1));

    // Back-to-back SET1, CLR, SET1
    issue(OP_SET1, 1'b0);
    chk("b2b_one_a", W'(is_one), W'(1));
    chk("b2b_ready_a", W'(cmd_ready), W'(1));
    issue(OP_CLR, 1'b0);
    chk("b2b_zero", W'(is_zero), W'(1));
    chk("b2b_ready_b", W'(cmd_ready), W'(1));
    issue(OP_SET1, 1'b0);
    chk("b2b_one_b", W'(is_one), W'(1));

    // Reset during the 7th UNLOAD word
    do_load(LOADVAL, -1);
    issue(OP_UNLOAD, 1'b0);
    repeat (7) step();
    chk("mid_unload_word7", W'(dout), W'(16'h0007));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_dout", W'(dout), '0);
    chk("rst_mid_dv", W'(dout_valid), '0);
    chk("rst_mid_q", q, '0);
    chk("rst_mid_is_zero", W'(is_zero), W'(1));
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", W'(cmd_ready), W'(1));
    do_load(LOADVAL2, -1);
    chk("post_rst_load_q", q, LOADVAL2);

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
